// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared definitions for the two-port memory arbiter.
//               Holds the data/address width, the default access latency
//               and the arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  // Data and address width shared by both ports and the memory side.
  localparam int WORD_SIZE       = 16;

  // Default memory access length in cycles (legal range 1..15).
  localparam int DEFAULT_LATENCY = 2;

  // Arbiter state encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_t;

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Fixed-priority arbiter sharing one single-ported memory
//               between an instruction-fetch port and a data port.
//               The data port wins over the fetch port. Each access holds
//               the memory strobes for exactly LATENCY cycles and is
//               completed with a one-cycle ready pulse on the granted port.
//
// Ports       : Clk      - rising-edge clock
//               Reset    - asynchronous active-high reset
//               i_req    - fetch request, held until i_ready
//               i_addr   - fetch address
//               i_rdata  - fetched word, valid while i_ready=1
//               i_ready  - fetch completion pulse
//               d_read   - data read request, held until d_ready
//               d_write  - data write request, held until d_ready
//               d_addr   - data address
//               d_wdata  - data write word
//               d_rdata  - data read word, valid while d_ready=1
//               d_ready  - data completion pulse
//               m_read   - memory read strobe
//               m_write  - memory write strobe
//               m_addr   - memory address
//               m_wdata  - memory write data
//               m_rdata  - memory read data, valid in last read cycle
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int LATENCY   = mem_arbiter_pkg::DEFAULT_LATENCY,
  parameter int WORD_SIZE = mem_arbiter_pkg::WORD_SIZE
) (
  input  logic                 Clk,
  input  logic                 Reset,
  // Instruction-fetch port
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_ready,
  // Data port
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ready,
  // Memory side
  output logic                 m_read,
  output logic                 m_write,
  output logic [WORD_SIZE-1:0] m_addr,
  output logic [WORD_SIZE-1:0] m_wdata,
  input  logic [WORD_SIZE-1:0] m_rdata
);

  import mem_arbiter_pkg::*;

  // Counter load value: the grant edge already accounts for one cycle.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t               state_q;
  logic [3:0]           cnt_q;
  logic                 m_read_q;
  logic                 m_write_q;
  logic [WORD_SIZE-1:0] m_addr_q;
  logic [WORD_SIZE-1:0] m_wdata_q;
  logic [WORD_SIZE-1:0] i_rdata_q;
  logic [WORD_SIZE-1:0] d_rdata_q;
  logic                 i_ready_q;
  logic                 d_ready_q;

  // A port whose ready pulse is in this cycle still holds its request for
  // one more cycle; masking it here prevents servicing it twice.
  logic d_elig;
  logic i_elig;
  assign d_elig = (d_read | d_write) & ~d_ready_q;
  assign i_elig = i_req & ~i_ready_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
    end else begin
      // Ready outputs are single-cycle pulses.
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (d_elig) begin
            // A simultaneous read+write request is treated as a write.
            state_q   <= ST_BUSY_D;
            cnt_q     <= CNT_LOAD;
            m_write_q <= d_write;
            m_read_q  <= ~d_write;
            m_addr_q  <= d_addr;
            m_wdata_q <= d_write ? d_wdata : '0;
          end else if (i_elig) begin
            state_q   <= ST_BUSY_I;
            cnt_q     <= CNT_LOAD;
            m_write_q <= 1'b0;
            m_read_q  <= 1'b1;
            m_addr_q  <= i_addr;
            m_wdata_q <= '0;
          end
        end

        ST_BUSY_I, ST_BUSY_D: begin
          if (cnt_q == 4'd0) begin
            if (state_q == ST_BUSY_I) begin
              i_rdata_q <= m_rdata;
              i_ready_q <= 1'b1;
            end else begin
              // Write completions leave the data read register untouched.
              if (!m_write_q) begin
                d_rdata_q <= m_rdata;
              end
              d_ready_q <= 1'b1;
            end
            state_q   <= ST_IDLE;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          cnt_q     <= 4'd0;
          m_read_q  <= 1'b0;
          m_write_q <= 1'b0;
          m_addr_q  <= '0;
          m_wdata_q <= '0;
        end
      endcase
    end
  end

  assign m_read  = m_read_q;
  assign m_write = m_write_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_ready = i_ready_q;
  assign d_ready = d_ready_q;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter (LATENCY=2).
//               Cycle 0 is the cycle a request is first driven; the bench
//               drives and samples 1 time unit after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic        Clk;
  logic        Reset;
  logic        i_req;
  logic [15:0] i_addr;
  logic [15:0] i_rdata;
  logic        i_ready;
  logic        d_read;
  logic        d_write;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_ready;
  logic        m_read;
  logic        m_write;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;

  int vectors;
  int miscompares;

  logic [15:0] mem [0:255];

  mem_arbiter #(
    .LATENCY  (2),
    .WORD_SIZE(16)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .i_req  (i_req),
    .i_addr (i_addr),
    .i_rdata(i_rdata),
    .i_ready(i_ready),
    .d_read (d_read),
    .d_write(d_write),
    .d_addr (d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_ready(d_ready),
    .m_read (m_read),
    .m_write(m_write),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory model: combinational read data, write captured on each strobed edge.
  assign m_rdata = m_read ? mem[m_addr[7:0]] : 16'h0000;
  always @(posedge Clk) begin
    if (m_write) mem[m_addr[7:0]] <= m_wdata;
  end

  // Mutual exclusion of strobes and of ready pulses.
  always @(negedge Clk) begin
    if (!Reset) begin
      vectors++;
      if ((m_read && m_write) || (i_ready && d_ready)) begin
        miscompares++;
        $display("FAIL exclusive: m_read=%b m_write=%b i_ready=%b d_ready=%b required no overlap",
                 m_read, m_write, i_ready, d_ready);
      end
    end
  end

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) next_cycle();
    vectors++;
    if ({m_read, m_write, i_ready, d_ready} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b required 0000", {m_read, m_write, i_ready, d_ready});
    end
    vectors++;
    if ({m_addr, m_wdata} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mbus: got %h required 0", {m_addr, m_wdata});
    end
    vectors++;
    if ({i_rdata, d_rdata} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rdata: got %h required 0", {i_rdata, d_rdata});
    end
    Reset = 1'b0;
  endtask

  task automatic test_ifetch();
    next_cycle();
    i_req  = 1'b1;
    i_addr = 16'h0010;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      vectors++;
      if (m_read !== (c <= 2)) begin
        miscompares++;
        $display("FAIL ifetch_mread c%0d: got %b required %b", c, m_read, (c <= 2));
      end
      if (c <= 2) begin
        vectors++;
        if (m_addr !== 16'h0010) begin
          miscompares++;
          $display("FAIL ifetch_maddr c%0d: got %h required 0010", c, m_addr);
        end
      end
      vectors++;
      if (i_ready !== (c == 3) || d_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL ifetch_ready c%0d: got i=%b d=%b required i=%b d=0", c, i_ready, d_ready, (c == 3));
      end
      if (c == 3) begin
        vectors++;
        if (i_rdata !== 16'hABCD) begin
          miscompares++;
          $display("FAIL ifetch_rdata: got %h required abcd", i_rdata);
        end
        i_req = 1'b0;
      end
    end
  endtask

  task automatic test_priority();
    next_cycle();
    i_req  = 1'b1;
    i_addr = 16'h0040;
    d_read = 1'b1;
    d_addr = 16'h0030;
    for (int c = 1; c <= 7; c++) begin
      logic        exp_rd;
      logic [15:0] exp_addr;
      next_cycle();
      exp_rd   = (c == 1) || (c == 2) || (c == 4) || (c == 5);
      exp_addr = (c <= 2) ? 16'h0030 : ((c == 4 || c == 5) ? 16'h0040 : 16'h0000);
      vectors++;
      if (m_read !== exp_rd || m_addr !== exp_addr) begin
        miscompares++;
        $display("FAIL prio_mbus c%0d: got rd=%b addr=%h required rd=%b addr=%h",
                 c, m_read, m_addr, exp_rd, exp_addr);
      end
      vectors++;
      if (d_ready !== (c == 3) || i_ready !== (c == 6)) begin
        miscompares++;
        $display("FAIL prio_ready c%0d: got d=%b i=%b required d=%b i=%b",
                 c, d_ready, i_ready, (c == 3), (c == 6));
      end
      if (c == 3) begin
        vectors++;
        if (d_rdata !== 16'h5555) begin
          miscompares++;
          $display("FAIL prio_drdata: got %h required 5555", d_rdata);
        end
        d_read = 1'b0;
      end
      if (c == 6) begin
        vectors++;
        if (i_rdata !== 16'h7777) begin
          miscompares++;
          $display("FAIL prio_irdata: got %h required 7777", i_rdata);
        end
        i_req = 1'b0;
      end
    end
  endtask

  task automatic test_write_read();
    next_cycle();
    d_write = 1'b1;
    d_addr  = 16'h0020;
    d_wdata = 16'h1234;
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      vectors++;
      if (m_write !== (c <= 2) || m_read !== 1'b0) begin
        miscompares++;
        $display("FAIL wr_strobe c%0d: got wr=%b rd=%b required wr=%b rd=0", c, m_write, m_read, (c <= 2));
      end
      if (c <= 2) begin
        vectors++;
        if (m_wdata !== 16'h1234 || m_addr !== 16'h0020) begin
          miscompares++;
          $display("FAIL wr_bus c%0d: got addr=%h data=%h required 0020/1234", c, m_addr, m_wdata);
        end
      end
      if (c == 3) begin
        vectors++;
        if (d_ready !== 1'b1 || d_rdata !== 16'h5555) begin
          miscompares++;
          $display("FAIL wr_done: got ready=%b rdata=%h required 1/5555", d_ready, d_rdata);
        end
        d_write = 1'b0;
      end
    end
    next_cycle();
    d_read = 1'b1;
    d_addr = 16'h0020;
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      vectors++;
      if (m_read !== (c <= 2) || d_ready !== (c == 3)) begin
        miscompares++;
        $display("FAIL rd_back c%0d: got rd=%b ready=%b required rd=%b ready=%b",
                 c, m_read, d_ready, (c <= 2), (c == 3));
      end
      if (c == 3) begin
        vectors++;
        if (d_rdata !== 16'h1234) begin
          miscompares++;
          $display("FAIL rd_back_data: got %h required 1234", d_rdata);
        end
        d_read = 1'b0;
      end
    end
  endtask

  task automatic test_hold();
    int nrd;
    int nrdy;
    nrd  = 0;
    nrdy = 0;
    next_cycle();
    i_req  = 1'b1;
    i_addr = 16'h0010;
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      if (m_read)  nrd++;
      if (i_ready) nrdy++;
      if (c == 4) i_req = 1'b0;
    end
    vectors++;
    if (nrd !== 2 || nrdy !== 1) begin
      miscompares++;
      $display("FAIL hold_single: got read_cycles=%0d readies=%0d required 2/1", nrd, nrdy);
    end
  endtask

  task automatic test_both();
    int nrd;
    int nwr;
    nrd = 0;
    nwr = 0;
    next_cycle();
    d_read  = 1'b1;
    d_write = 1'b1;
    d_addr  = 16'h0050;
    d_wdata = 16'hBEEF;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      if (m_read)  nrd++;
      if (m_write) nwr++;
      if (c == 3) begin
        vectors++;
        if (d_ready !== 1'b1 || d_rdata !== 16'h1234) begin
          miscompares++;
          $display("FAIL both_done: got ready=%b rdata=%h required 1/1234", d_ready, d_rdata);
        end
        d_read  = 1'b0;
        d_write = 1'b0;
      end
    end
    vectors++;
    if (nrd !== 0 || nwr !== 2) begin
      miscompares++;
      $display("FAIL both_strobes: got read_cycles=%0d write_cycles=%0d required 0/2", nrd, nwr);
    end
    vectors++;
    if (mem[8'h50] !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL both_memword: got %h required beef", mem[8'h50]);
    end
  endtask

  task automatic test_reset_abort();
    int nrdy;
    nrdy = 0;
    next_cycle();
    d_write = 1'b1;
    d_addr  = 16'h0060;
    d_wdata = 16'h9999;
    next_cycle();
    vectors++;
    if (m_write !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_pre: got m_write=%b required 1", m_write);
    end
    #2;
    Reset = 1'b1;
    #1;
    vectors++;
    if (m_write !== 1'b0 || m_addr !== 16'h0000) begin
      miscompares++;
      $display("FAIL abort_async: got m_write=%b addr=%h required 0/0000", m_write, m_addr);
    end
    d_write = 1'b0;
    next_cycle();
    Reset = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      if (d_ready || m_write || m_read) nrdy++;
    end
    vectors++;
    if (nrdy !== 0) begin
      miscompares++;
      $display("FAIL abort_quiet: got %0d active cycles required 0", nrdy);
    end
    vectors++;
    if (mem[8'h60] !== 16'h0000) begin
      miscompares++;
      $display("FAIL abort_memword: got %h required 0000", mem[8'h60]);
    end
    i_req  = 1'b1;
    i_addr = 16'h0010;
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      vectors++;
      if (m_read !== (c <= 2) || i_ready !== (c == 3)) begin
        miscompares++;
        $display("FAIL abort_restart c%0d: got rd=%b ready=%b required rd=%b ready=%b",
                 c, m_read, i_ready, (c <= 2), (c == 3));
      end
      if (c == 3) begin
        vectors++;
        if (i_rdata !== 16'hABCD) begin
          miscompares++;
          $display("FAIL abort_restart_data: got %h required abcd", i_rdata);
        end
        i_req = 1'b0;
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Reset   = 1'b1;
    i_req   = 1'b0;
    i_addr  = 16'h0000;
    d_read  = 1'b0;
    d_write = 1'b0;
    d_addr  = 16'h0000;
    d_wdata = 16'h0000;
    for (int k = 0; k < 256; k++) mem[k] = 16'h0000;
    mem[8'h10] = 16'hABCD;
    mem[8'h30] = 16'h5555;
    mem[8'h40] = 16'h7777;

    test_reset();
    test_ifetch();
    test_priority();
    test_write_read();
    test_hold();
    test_both();
    test_reset_abort();

    next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire
